// File: rtl/cmul_pkg.sv
// Shared types and width helpers for the sequential complex multiplier.
package cmul_pkg;

    // Controller states; P3 is only visited by the 4-multiply schedule
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P1   = 3'd2,
        P2   = 3'd3,
        P3   = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic MODE_GAUSS = 1'b0;
    localparam logic MODE_FOUR  = 1'b1;

    // Operand sums/differences carry one guard bit
    function automatic int unsigned sum_w(input int unsigned w);
        return w + 1;
    endfunction

    // Product of two sum-width operands
    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w + 2;
    endfunction

    // Accumulator keeps one more bit than a product
    function automatic int unsigned acc_w(input int unsigned w);
        return 2 * w + 3;
    endfunction

    // Result width; exact for every operand combination
    function automatic int unsigned out_w(input int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/cmul_shared_mult.sv
// Single time-shared signed multiplier used by every partial-product step.
module cmul_shared_mult #(
    parameter int unsigned OPW = 5
) (
    input  logic signed [OPW-1:0]   x,
    input  logic signed [OPW-1:0]   y,
    output logic signed [2*OPW-1:0] p
);

    // Full-precision signed product
    assign p = x * y;

endmodule

// File: rtl/cmul_seq_ctrl.sv
// Sequential complex multiply (A+jB)(C+jD) with one shared real multiplier,
// selectable 3-multiply (Gauss) or 4-multiply schedule per transaction.
module cmul_seq_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           mode,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    input  logic [W-1:0]   c_in,
    input  logic [W-1:0]   d_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W:0]   re_out,
    output logic [2*W:0]   im_out,
    output logic           busy
);

    import cmul_pkg::*;

    localparam int unsigned SW = sum_w(W);
    localparam int unsigned PW = prod_w(W);
    localparam int unsigned AW = acc_w(W);
    localparam int unsigned OW = out_w(W);

    state_t                state;
    logic                  mode_q;
    logic signed [W-1:0]   a_q, b_q, c_q, d_q;
    logic signed [AW-1:0]  re_acc, im_acc;
    logic signed [AW-1:0]  re_nxt, im_nxt;

    logic signed [SW-1:0]  a_x, b_x, c_x, d_x;
    logic signed [SW-1:0]  sum_ab, sum_cd, dif_dc;
    logic signed [SW-1:0]  mul_x, mul_y;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  prod_x;

    // Sign-extended operands and the Gauss pre-adds
    always_comb begin
        a_x    = {a_q[W-1], a_q};
        b_x    = {b_q[W-1], b_q};
        c_x    = {c_q[W-1], c_q};
        d_x    = {d_q[W-1], d_q};
        sum_ab = a_x + b_x;
        sum_cd = c_x + d_x;
        dif_dc = d_x - c_x;
    end

    // Per-state multiplier operand selection
    always_comb begin
        mul_x = a_x;
        mul_y = c_x;
        case (state)
            P0: begin
                if (mode_q == MODE_GAUSS) begin
                    mul_x = c_x;
                    mul_y = sum_ab;
                end else begin
                    mul_x = a_x;
                    mul_y = c_x;
                end
            end
            P1: begin
                if (mode_q == MODE_GAUSS) begin
                    mul_x = a_x;
                    mul_y = dif_dc;
                end else begin
                    mul_x = b_x;
                    mul_y = d_x;
                end
            end
            P2: begin
                if (mode_q == MODE_GAUSS) begin
                    mul_x = b_x;
                    mul_y = sum_cd;
                end else begin
                    mul_x = a_x;
                    mul_y = d_x;
                end
            end
            P3: begin
                mul_x = b_x;
                mul_y = c_x;
            end
            default: begin
                mul_x = a_x;
                mul_y = c_x;
            end
        endcase
    end

    cmul_shared_mult #(
        .OPW (SW)
    ) u_mult (
        .x (mul_x),
        .y (mul_y),
        .p (prod)
    );

    // Accumulator update for the current schedule step
    always_comb begin
        prod_x = {prod[PW-1], prod};
        re_nxt = re_acc;
        im_nxt = im_acc;
        case (state)
            P0: begin
                re_nxt = prod_x;
                if (mode_q == MODE_GAUSS) im_nxt = prod_x;
            end
            P1: begin
                if (mode_q == MODE_GAUSS) im_nxt = im_acc + prod_x;
                else                      re_nxt = re_acc - prod_x;
            end
            P2: begin
                if (mode_q == MODE_GAUSS) re_nxt = re_acc - prod_x;
                else                      im_nxt = prod_x;
            end
            P3: im_nxt = im_acc + prod_x;
            default: begin
                re_nxt = re_acc;
                im_nxt = im_acc;
            end
        endcase
    end

    // Controller FSM with registered handshake outputs and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= MODE_GAUSS;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            re_acc    <= '0;
            im_acc    <= '0;
            re_out    <= '0;
            im_out    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            re_acc <= re_nxt;
            im_acc <= im_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a_in;
                        b_q      <= b_in;
                        c_q      <= c_in;
                        d_q      <= d_in;
                        mode_q   <= mode;
                        state    <= P0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                P0: state <= P1;
                P1: state <= P2;
                P2: begin
                    if (mode_q == MODE_GAUSS) begin
                        state     <= DONE;
                        re_out    <= re_nxt[OW-1:0];
                        im_out    <= im_nxt[OW-1:0];
                        out_valid <= 1'b1;
                    end else begin
                        state <= P3;
                    end
                end
                P3: begin
                    state     <= DONE;
                    re_out    <= re_nxt[OW-1:0];
                    im_out    <= im_nxt[OW-1:0];
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
